// File: rtl/tpu_host_driver.sv
// tpu_host_driver
// Host-side master for the 2x2 systolic TPU pin interface. Accepts one matrix
// job over a valid/ready command port, streams the eight operand bytes into
// the TPU with load_en asserted, waits for the TPU done flag, captures the
// eight result bytes and returns the four 16-bit results on a valid/ready
// response port.
//
// Ports:
//   clk, rst                      clock shared with the TPU, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_weights, cmd_inputs       byte k of each at [8k+7:8k]
//   cmd_transpose, cmd_relu       job mode bits
//   rsp_valid/rsp_ready           response handshake
//   rsp_data                      {c11, c10, c01, c00}
//   rsp_timeout                   response is a timeout (rsp_data = 0)
//   busy                          high whenever not idle
//   tpu_ui_in, tpu_uio_in         data byte / {5'b0, relu, transpose, load_en}
//   tpu_uo_out, tpu_uio_out       result byte / bit7 = done
//
// Optional feature: define TPU_HOST_TIMEOUT_EN to abort a job whose done flag
// has not appeared within TIMEOUT_CYCLES cycles of waiting.
module tpu_host_driver #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_weights,
  input  logic [31:0] cmd_inputs,
  input  logic        cmd_transpose,
  input  logic        cmd_relu,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic [7:0]  tpu_uio_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  count;
  // Remaining operand bytes (weights 1..3 then inputs 0..3), shifted out LSB first.
  logic [55:0] job_r;
  // Result bytes 0..6, shifted in from the top so byte 0 ends up in [7:0].
  logic [55:0] cap_r;

  // Only the done bit of tpu_uio_out is meaningful.
  logic unused_uio_bits;
  assign unused_uio_bits = ^tpu_uio_out[6:0];

  // Range check on the timeout limit, evaluated at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("tpu_host_driver: TIMEOUT_CYCLES must be 1..255");
  end

`ifdef TPU_HOST_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Job sequencer: state, counters, data registers and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= 3'd0;
      job_r      <= 56'd0;
      cap_r      <= 56'd0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 64'd0;
      busy       <= 1'b0;
      tpu_ui_in  <= 8'd0;
      tpu_uio_in <= 8'd0;
`ifdef TPU_HOST_TIMEOUT_EN
      wait_cnt    <= 8'd0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            state      <= S_LOAD;
            count      <= 3'd0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            job_r      <= {cmd_inputs, cmd_weights[31:8]};
            tpu_ui_in  <= cmd_weights[7:0];
            tpu_uio_in <= {5'd0, cmd_relu, cmd_transpose, 1'b1};
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_LOAD: begin
          if (count == 3'd7) begin
            state      <= S_WAIT;
            tpu_ui_in  <= 8'd0;
            tpu_uio_in <= {tpu_uio_in[7:1], 1'b0};  // drop load_en, keep mode bits
`ifdef TPU_HOST_TIMEOUT_EN
            wait_cnt   <= 8'd0;
`endif
          end else begin
            count     <= count + 3'd1;
            tpu_ui_in <= job_r[7:0];
            job_r     <= {8'd0, job_r[55:8]};
          end
        end

        S_WAIT: begin
          if (tpu_uio_out[7]) begin
            state <= S_CAPTURE;
            count <= 3'd1;
            cap_r <= {tpu_uo_out, cap_r[55:8]};
`ifdef TPU_HOST_TIMEOUT_EN
          end else if (wait_cnt == TIMEOUT_LIMIT) begin
            state       <= S_RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_data    <= 64'd0;
            tpu_uio_in  <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`else
          end else begin
            state <= S_WAIT;
`endif
          end
        end

        S_CAPTURE: begin
          // Bytes 1..7 arrive on consecutive cycles regardless of done.
          if (count == 3'd7) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_data   <= {tpu_uo_out, cap_r};
            tpu_uio_in <= 8'd0;
          end else begin
            count <= count + 3'd1;
            cap_r <= {tpu_uo_out, cap_r[55:8]};
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef TPU_HOST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
          end else begin
            state <= S_RESP;
          end
        end

        default: begin
          state      <= S_IDLE;
          rsp_valid  <= 1'b0;
          busy       <= 1'b0;
          cmd_ready  <= 1'b0;
          tpu_ui_in  <= 8'd0;
          tpu_uio_in <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver with a behavioural TPU stub that records
// the load stream and answers either with fixed bytes 0x11..0x88 or with the
// 2x2 product C = W * X of the loaded operands.
module tb_tpu_host_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_weights = 32'd0;
  logic [31:0] cmd_inputs = 32'd0;
  logic        cmd_transpose = 1'b0;
  logic        cmd_relu = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;
  logic [7:0]  tpu_ui_in;
  logic [7:0]  tpu_uio_in;
  logic [7:0]  tpu_uo_out = 8'd0;
  logic [7:0]  tpu_uio_out = 8'd0;

  int passed = 0;
  int total = 0;
  int n;

  tpu_host_driver #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_weights(cmd_weights), .cmd_inputs(cmd_inputs),
    .cmd_transpose(cmd_transpose), .cmd_relu(cmd_relu),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
    .tpu_ui_in(tpu_ui_in), .tpu_uio_in(tpu_uio_in),
    .tpu_uo_out(tpu_uo_out), .tpu_uio_out(tpu_uio_out)
  );

  always #5 clk = ~clk;

  // ---------------- TPU stub ----------------
  int         done_delay = 5;
  logic       use_matmul = 1'b0;
  logic       stuck_low = 1'b0;
  logic [7:0] ld_bytes [8];
  logic [7:0] ld_uio [8];
  int         ld_cnt = 0;
  logic       in_load = 1'b0;
  logic       armed = 1'b0;
  int         gap = 0;
  int         out_idx = 0;

  function automatic logic [7:0] res_byte(input int idx);
    logic [15:0] c;
    int i, j;
    if (!use_matmul) return 8'(8'h11 * (idx + 1));
    i = (idx / 2) / 2;
    j = (idx / 2) % 2;
    c = 16'(ld_bytes[2*i] * ld_bytes[4 + j]) + 16'(ld_bytes[2*i+1] * ld_bytes[6 + j]);
    return (idx % 2 == 0) ? c[7:0] : c[15:8];
  endfunction

  function automatic logic [63:0] pack8(input logic [7:0] b [8]);
    logic [63:0] p = 64'd0;
    for (int k = 0; k < 8; k++) p[8*k +: 8] = b[k];
    return p;
  endfunction

  always @(negedge clk) begin
    tpu_uio_out <= 8'd0;
    tpu_uo_out  <= 8'd0;
    if (rst) begin
      ld_cnt <= 0; in_load <= 1'b0; armed <= 1'b0; gap <= 0; out_idx <= 0;
    end else if (tpu_uio_in[0]) begin
      if (!in_load) begin
        ld_bytes[0] <= tpu_ui_in; ld_uio[0] <= tpu_uio_in; ld_cnt <= 1;
      end else begin
        if (ld_cnt < 8) begin ld_bytes[ld_cnt] <= tpu_ui_in; ld_uio[ld_cnt] <= tpu_uio_in; end
        ld_cnt <= ld_cnt + 1;
      end
      in_load <= 1'b1; armed <= 1'b1; gap <= 0; out_idx <= 0;
    end else begin
      in_load <= 1'b0;
      if (armed && !stuck_low) begin
        if (gap < done_delay - 1) gap <= gap + 1;
        else begin
          if (out_idx == 0) tpu_uio_out <= 8'h80;  // done only with byte 0
          tpu_uo_out <= res_byte(out_idx);
          out_idx <= out_idx + 1;
          if (out_idx == 7) armed <= 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive a command from a negedge, return #1 after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [31:0] x, input logic t, input logic r);
    bit ok = 1'b0;
    cmd_weights = w; cmd_inputs = x; cmd_transpose = t; cmd_relu = r; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("cmd_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Negedges counted from the first one after the call; -1 if none in bound.
  task automatic wait_rsp(input int bound, output int cnt);
    cnt = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rsp_valid) begin cnt = i; break; end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_outs", {rsp_data}, 64'd0);
    chk("rst_ctrl", {56'd0, tpu_ui_in}, 64'd0);
    chk("rst_flags", {59'd0, tpu_uio_in[0], busy, rsp_valid, rsp_timeout, cmd_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // Job A: fixed stub bytes, load stream check, latency with done 5 cycles after load
    done_delay = 5; use_matmul = 1'b0;
    send(32'h04030201, 32'h08070605, 1'b0, 1'b0);
    chk("A_busy", 64'(busy), 64'd1);
    chk("A_uio_first", 64'(tpu_uio_in), 64'h01);
    wait_rsp(100, n);
    chk("A_latency", 64'(n), 64'd20);
    chk("A_rsp_data", rsp_data, 64'h8877665544332211);
    chk("A_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("A_load_bytes", pack8(ld_bytes), 64'h0807060504030201);
    chk("A_load_cycles", 64'(ld_cnt), 64'd8);
    chk("A_load_uio", pack8(ld_uio), 64'h0101010101010101);

    // Response back-pressure with a new command already pending (job B)
    use_matmul = 1'b1;
    cmd_weights = 32'h01000001; cmd_inputs = 32'h08070605;
    cmd_transpose = 1'b0; cmd_relu = 1'b0; cmd_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("hold_rsp_data", rsp_data, 64'h8877665544332211);
    chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("hold_no_load", 64'(tpu_uio_in), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("hs_idle", {62'd0, busy, cmd_ready}, 64'd1);
    chk("hs_not_yet_loaded", 64'(tpu_uio_in), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("B_accepted_next", {62'd0, busy, tpu_uio_in[0]}, 64'd3);
    wait_rsp(100, n);
    chk("B_latency", 64'(n), 64'd20);
    chk("B_identity", rsp_data, 64'h0008000700060005);
    handshake();
    @(negedge clk);

    // Job C: transpose mode bit, short done delay
    done_delay = 2; use_matmul = 1'b0;
    send(32'hA0B0C0D0, 32'h11223344, 1'b1, 1'b0);
    chk("C_uio_load", 64'(tpu_uio_in), 64'h03);
    repeat (9) @(negedge clk);
    chk("C_uio_wait", {48'd0, tpu_uio_in, tpu_ui_in}, 64'h0200);
    wait_rsp(100, n);
    chk("C_latency", 64'(n), 64'd8);
    chk("C_rsp_data", rsp_data, 64'h8877665544332211);
    chk("C_load_bytes", pack8(ld_bytes), 64'h11223344A0B0C0D0);
    chk("C_load_uio", pack8(ld_uio), 64'h0303030303030303);
    chk("C_uio_resp", 64'(tpu_uio_in), 64'd0);
    handshake();
    @(negedge clk);

    // Job D: reset during load count 3
    send(32'hDDCCBBAA, 32'h00000000, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("D_byte3", 64'(tpu_ui_in), 64'hDD);
    #2 rst = 1'b1;
    #1;
    chk("D_rst_data", rsp_data, 64'd0);
    chk("D_rst_outs", {40'd0, tpu_ui_in, tpu_uio_in, 3'd0, cmd_ready, busy, rsp_valid, rsp_timeout, 1'b0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("D_ready_after_rst", {62'd0, cmd_ready, busy}, 64'd2);
    @(negedge clk);

    // Job E: real product after the aborted job
    done_delay = 3; use_matmul = 1'b1;
    send(32'h03000002, 32'h04030201, 1'b0, 1'b0);
    wait_rsp(100, n);
    chk("E_latency", 64'(n), 64'd18);
    chk("E_product", rsp_data, 64'h000C000900040002);
    chk("E_load_bytes", pack8(ld_bytes), 64'h0403020103000002);
    chk("E_load_cycles", 64'(ld_cnt), 64'd8);
    handshake();
    @(negedge clk);

    // Job F: done never rises, relu bit set
    stuck_low = 1'b1;
    send(32'h01010101, 32'h01010101, 1'b0, 1'b1);
    chk("F_uio_load", 64'(tpu_uio_in), 64'h05);
`ifdef TPU_HOST_TIMEOUT_EN
    wait_rsp(100, n);
    chk("F_timeout_latency", 64'(n), 64'd28);
    chk("F_timeout_flag", 64'(rsp_timeout), 64'd1);
    chk("F_timeout_data", rsp_data, 64'd0);
    handshake();
    chk("F_timeout_cleared", {62'd0, rsp_timeout, busy}, 64'd0);
`else
    wait_rsp(300, n);
    chk("F_no_response", 64'(n), 64'hFFFFFFFFFFFFFFFF);
    chk("F_still_busy", {62'd0, busy, rsp_timeout}, 64'd2);
`endif
    rst = 1'b1;
    @(negedge clk);
    stuck_low = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
# tpu_host_driver

Host-side master for the 2x2 systolic TPU pin interface. It accepts one matrix job (four weight bytes, four input bytes, mode bits) over a valid/ready command port and serialises it onto the TPU's `ui_in`/`uio_in` load protocol. It then waits for the TPU's `done` flag and captures the eight result bytes from `uo_out`. The four 16-bit results are returned on a valid/ready response port. It sits in the test harness or SoC wrapper, directly facing `tt_um_tpu`, and shares its reset.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles allowed in WAIT before a timeout response (used only with `TPU_HOST_TIMEOUT_EN`); 1..255.

Ports:
- `clk` in 1: single clock, shared with the TPU.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_weights` in 32: byte k = `weight k`, k = 0..3, at [8k+7:8k].
- `cmd_inputs` in 32: byte k = `input k`, same packing.
- `cmd_transpose` in 1, `cmd_relu` in 1: job mode bits.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out 64: {c11, c10, c01, c00}, 16 bits each.
- `rsp_timeout` out 1: response is a timeout; `rsp_data` = 0.
- `busy` out 1: high in any state other than IDLE.
- `tpu_ui_in` out 8: data byte to the TPU.
- `tpu_uio_in` out 8: bit0 `load_en`, bit1 transpose, bit2 activation, bits 7:3 = 0.
- `tpu_uo_out` in 8: result byte from the TPU.
- `tpu_uio_out` in 8: bit7 = done; other bits ignored.

## Operation
- States: IDLE, LOAD, WAIT, CAPTURE, RESP.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`, register all command fields and clear the 3-bit count. Next state: LOAD.
- **LOAD** (8 cycles)
  - `tpu_uio_in[0]` = 1.
  - `tpu_ui_in` = byte[count] from the concatenation {inputs, weights}: counts 0..3 drive weights 0..3, counts 4..7 drive inputs 0..3.
  - At count 7, go to WAIT.
- **WAIT**
  - `load_en` = 0 and `tpu_ui_in` = 0.
  - The first cycle with `tpu_uio_out[7]` = 1 captures `tpu_uo_out` as byte 0. Next state: CAPTURE, with count = 1.
- **CAPTURE**
  - Captures one byte per cycle, counts 1..7, unconditionally. A drop of `done` mid-capture is ignored.
  - Byte order: c00 lo, c00 hi, c01 lo, c01 hi, c10 lo, c10 hi, c11 lo, c11 hi.
  - After count 7, go to RESP.
- **RESP**
  - `rsp_valid` = 1, with `rsp_data` stable.
  - On `rsp_ready`, return to IDLE.
- `tpu_uio_in[1]` and `tpu_uio_in[2]` carry the registered mode bits from LOAD through CAPTURE, and are 0 in IDLE and RESP.
- `cmd_ready` = 0 outside IDLE; commands presented then are not accepted.
- Reset, including mid-job:
  - State returns to IDLE and the partial job is discarded.
  - All outputs go to 0 except `cmd_ready`, which becomes 1 in the first cycle after `rst` deasserts.
  - `rsp_data` and the capture register are cleared.

## Timing
- Acceptance happens at edge E0. `load_en` is high for exactly the 8 cycles following E0.
- `done` sampled high at edge Ed captures byte 0. Byte 7 is captured at Ed+7.
- `rsp_valid` rises after edge Ed+7 and is first visible in the following cycle.
- Minimum acceptance-to-`rsp_valid` latency is 8 + W + 8 cycles, where W is the number of WAIT cycles (W ≥ 1).
- Back-to-back jobs: after `rsp_valid & rsp_ready`, the block is in IDLE next cycle and accepts the new command at the following edge. There is no command/response overlap.
- All outputs are registered; there is no combinational path from `tpu_*` inputs to outputs.

## Configuration
- `TPU_HOST_TIMEOUT_EN` defined:
  - An 8-bit WAIT counter runs, cleared on entry to WAIT.
  - If `done` has not been seen when the counter reaches `TIMEOUT_CYCLES`, go to RESP with `rsp_timeout` = 1 and `rsp_data` = 0.
  - If `done` rises in the same cycle the limit is reached, `done` wins: a normal capture proceeds.
- Undefined:
  - WAIT lasts indefinitely.
  - `rsp_timeout` is tied to 0 and no counter is built.

## Test plan
- TPU stub raises `done` 5 cycles after the last load, then drives bytes 0x11..0x88 → `rsp_data` = 0x8877665544332211, `rsp_timeout` = 0.
- Command weights 0x04030201, inputs 0x08070605 → `tpu_ui_in` sequence 01,02,03,04,05,06,07,08 with `load_en` high exactly 8 cycles; `tpu_uio_in` = 0x01 throughout with both mode bits clear.
- Integration with the real TPU, weights = identity (0x01000001), inputs 0x08070605, transpose = 0, relu = 0 → `rsp_data` = 0x0008000700060005.
- `rsp_ready` held low 10 cycles → `rsp_valid` and `rsp_data` held stable, `cmd_ready` = 0; a new `cmd_valid` is not accepted until one cycle after the response handshake.
- With the macro, `TIMEOUT_CYCLES` = 20 and `done` stuck low → `rsp_valid` with `rsp_timeout` = 1 and `rsp_data` = 0, 20 cycles after WAIT entry. Without the macro, no response occurs within 300 cycles.
- `rst` pulsed during LOAD count 3 → all outputs 0 immediately (asynchronous); the next job completes correctly with no stale bytes.
